// File: rtl/bpu_update_sched.sv
// Commit-side update scheduler for the branch predictor's single update port.
// Buffers up to COMMIT_WIDTH resolved updates per cycle in program order and
// issues at most one per cycle from the head of a circular queue.
// Optional build macro: BPU_UPD_PERF_EN adds stall_cnt_o / upd_cnt_o counters.
module bpu_update_sched #(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned PLEN         = 32,
  parameter int unsigned QUEUE_DEPTH  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
  input  logic [COMMIT_WIDTH*PLEN-1:0]     commit_pc_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_is_cond_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_taken_i,
  input  logic [COMMIT_WIDTH*PLEN-1:0]     commit_target_i,
  output logic                             commit_ready_o,
  input  logic                             upd_ready_i,
  output logic                             update_valid_o,
  output logic [PLEN-1:0]                  update_pc_o,
  output logic                             update_is_cond_o,
  output logic                             update_taken_o,
  output logic [PLEN-1:0]                  update_target_o,
  output logic [$clog2(QUEUE_DEPTH):0]     occupancy_o
`ifdef BPU_UPD_PERF_EN
  ,
  output logic [31:0]                      stall_cnt_o,
  output logic [31:0]                      upd_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC   = CntW'(QUEUE_DEPTH);
  localparam logic [CntW-1:0] ReadyMax = CntW'(QUEUE_DEPTH - COMMIT_WIDTH);

  logic [PLEN-1:0] pc_q     [QUEUE_DEPTH];
  logic [PLEN-1:0] target_q [QUEUE_DEPTH];
  logic            is_cond_q[QUEUE_DEPTH];
  logic            taken_q  [QUEUE_DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [CntW-1:0] push_n;
  logic [PtrW-1:0] wr_idx [COMMIT_WIDTH];
  logic            push_en;
  logic            pop_en;

  // Ready depends on the registered count only: a same-cycle pop gives no credit.
  assign commit_ready_o = (count_q <= ReadyMax);
  assign push_en        = commit_ready_o && (|commit_valid_i);
  assign update_valid_o = (count_q != '0);
  assign pop_en         = update_valid_o && upd_ready_i;
  assign occupancy_o    = count_q;

  // Compact valid slots: each valid slot lands at tail + (valid slots below it).
  always_comb begin
    push_n = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      wr_idx[i] = tail_q + push_n[PtrW-1:0];
      push_n    = push_n + CntW'(commit_valid_i[i]);
    end
  end

  // Pointer and count next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (push_en ? push_n : '0) - CntW'(pop_en);
    if (push_en) begin
      tail_d = tail_q + push_n[PtrW-1:0];
    end
    if (pop_en) begin
      head_d = head_q + PtrW'(1);
    end
  end

  // Pointer and count registers; reset discards all queued updates.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (commit_valid_i[i]) begin
          pc_q[wr_idx[i]]      <= commit_pc_i[i*PLEN +: PLEN];
          target_q[wr_idx[i]]  <= commit_target_i[i*PLEN +: PLEN];
          is_cond_q[wr_idx[i]] <= commit_is_cond_i[i];
          taken_q[wr_idx[i]]   <= commit_taken_i[i];
        end
      end
    end
  end

  // Head entry drives the update port, forced to zero while empty.
  always_comb begin
    update_pc_o      = '0;
    update_is_cond_o = 1'b0;
    update_taken_o   = 1'b0;
    update_target_o  = '0;
    if (update_valid_o) begin
      update_pc_o      = pc_q[head_q];
      update_is_cond_o = is_cond_q[head_q];
      update_taken_o   = taken_q[head_q];
      update_target_o  = target_q[head_q];
    end
  end

`ifdef BPU_UPD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] upd_cnt_q;

  // Rejected commit cycles and issued updates; both wrap at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      upd_cnt_q   <= '0;
    end else begin
      if ((|commit_valid_i) && !commit_ready_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (pop_en) begin
        upd_cnt_q <= upd_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign upd_cnt_o   = upd_cnt_q;
`endif

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DepthC);
  a_push_ready:  assert property (@(posedge clk_i) disable iff (rst_i) push_en |-> commit_ready_o);

endmodule
